bram_dp_clr: RTL and testbench
==============================

// Module: bram_dp_clr
// PURPOSE
//  Dual-port block RAM: port A read/write with byte enables, port B read-only.
//  Read latency is configurable (1 or 2 cycles) and each read returns a valid strobe.
//  A built-in clear sequencer fills the whole array with INIT_VALUE after reset.
//  Sits between the capture/processing datapath (port A) and the readout/host logic (port B).
// PARAMETERS
//  BRAM_ADDR_WIDTH  15            address bits; depth = 1<<BRAM_ADDR_WIDTH words
//  BRAM_DATA_WIDTH  16            word width; must be a multiple of 8
//  READ_LATENCY     1             1 = registered read, 2 = additional output register
//  WRITE_MODE       "READ_FIRST"  same-address read/write collision: "READ_FIRST" | "WRITE_FIRST"
//  INIT_VALUE       0             word written to every address by the clear sequencer
// PORTS
//  clk            in   1       single clock; all logic on posedge
//  rst            in   1       synchronous, active-high reset
//  a_chipselect_n in   1       port A select, active low
//  a_write_n      in   1       port A write strobe, active low
//  a_read_n       in   1       port A read strobe, active low
//  a_byteen_n     in   DW/8    per-byte write enable, active low; bit i -> data[8i+7:8i]
//  a_addr         in   AW      port A address
//  a_data_in      in   DW      port A write data
//  a_data_out     out  DW      port A read data
//  a_valid        out  1       one-cycle pulse: a_data_out holds new read data
//  b_chipselect_n in   1       port B select, active low
//  b_read_n       in   1       port B read strobe, active low
//  b_addr         in   AW      port B address
//  b_data_out     out  DW      port B read data
//  b_valid        out  1       one-cycle pulse: b_data_out holds new read data
//  clr_busy       out  1       high while the clear sequencer runs; all accesses ignored
// BEHAVIOUR
//  - Reset (rst=1 at posedge): a_data_out=0, b_data_out=0, a_valid=0, b_valid=0, pipeline flushed,
//    clear counter=0, clr_busy=1 from the next cycle. Reads in flight are dropped (no valid).
//  - FSM states: CLEAR -> RUN. CLEAR writes INIT_VALUE to address cnt each cycle, cnt++.
//    After address DEPTH-1 is written, go to RUN: clr_busy=0. CLEAR takes exactly DEPTH cycles.
//    rst asserted during CLEAR restarts at address 0. rst in RUN re-enters CLEAR.
//  - In CLEAR: chipselects, strobes and addresses are ignored; valid outputs stay 0.
//  - Write accepted (RUN): cs_n=0, write_n=0 -> bytes with byteen_n[i]=0 updated at that edge;
//    other bytes keep their value. byteen_n all ones -> no change.
//  - Read accepted (RUN): cs_n=0, read_n=0 at edge N -> data_out updated and valid=1 for exactly
//    one cycle at edge N+READ_LATENCY. Back-to-back reads -> one result per cycle, in order.
//  - data_out holds its last value when no read completes; valid=0 in those cycles.
//  - Port A read and write in the same cycle (same address): READ_FIRST -> old word returned;
//    WRITE_FIRST -> merged word (new bytes where enabled, old elsewhere) returned.
//  - Port A write and port B read at the same address in the same cycle: same WRITE_MODE rule
//    for b_data_out. Different addresses: independent.
//  - Port B has no write path. Ports do not interact except for the collision rule above.
//  - Addresses are full-range; no wrap-around or bounds check needed (depth = 2^AW).
// TESTING
//  - Reset, AW=4: clr_busy=1 for exactly 16 cycles; then B reads 0..15 -> all INIT_VALUE, b_valid per read.
//  - Reset at cycle 5 of CLEAR -> counter restarts; clr_busy high 16 more cycles; mem fully cleared.
//  - READ_LATENCY=1 and 2: A writes 0xBEEF @3, B reads @3 next cycle -> 0xBEEF with b_valid
//    exactly 1 / 2 cycles after the read; 4 back-to-back reads -> 4 consecutive valid pulses.
//  - Byte enables: mem[7]=0x1234, write 0xABCD with a_byteen_n=2'b10 -> read 0x12CD.
//  - Collision: mem[2]=0x1111, A writes 0x2222 @2 while B reads @2 -> READ_FIRST 0x1111,
//    WRITE_FIRST 0x2222; a subsequent read returns 0x2222 in both modes.
//  - Access during CLEAR: A write 0x5555 @0 while clr_busy=1 -> ignored, read after clear gives INIT_VALUE.

Source files
------------

// File: rtl/bram_dp_clr.sv
// Dual-port block RAM: port A read/write with byte enables, port B read-only.
// Configurable read latency with valid strobes; a clear sequencer fills the array after reset.
module bram_dp_clr #(
  parameter int unsigned                  BRAM_ADDR_WIDTH = 15,
  parameter int unsigned                  BRAM_DATA_WIDTH = 16,
  parameter int unsigned                  READ_LATENCY    = 1,
  parameter string                        WRITE_MODE      = "READ_FIRST",
  parameter logic [BRAM_DATA_WIDTH-1:0]   INIT_VALUE      = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           a_chipselect_n,
  input  logic                           a_write_n,
  input  logic                           a_read_n,
  input  logic [BRAM_DATA_WIDTH/8-1:0]   a_byteen_n,
  input  logic [BRAM_ADDR_WIDTH-1:0]     a_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]     a_data_in,
  output logic [BRAM_DATA_WIDTH-1:0]     a_data_out,
  output logic                           a_valid,
  input  logic                           b_chipselect_n,
  input  logic                           b_read_n,
  input  logic [BRAM_ADDR_WIDTH-1:0]     b_addr,
  output logic [BRAM_DATA_WIDTH-1:0]     b_data_out,
  output logic                           b_valid,
  output logic                           clr_busy
);

  localparam int unsigned DEPTH       = 1 << BRAM_ADDR_WIDTH;
  localparam int unsigned NB          = BRAM_DATA_WIDTH / 8;
  localparam bit          WRITE_FIRST = (WRITE_MODE == "WRITE_FIRST");

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                       state, state_nxt;
  logic [BRAM_ADDR_WIDTH-1:0]   cnt, cnt_nxt;

  logic [BRAM_DATA_WIDTH-1:0]   mem [DEPTH];

  logic                         run, clr_we;
  logic                         a_we, a_re, b_re;
  logic [BRAM_DATA_WIDTH-1:0]   a_old, b_old, a_new, a_rd_word, b_rd_word;

  logic [BRAM_DATA_WIDTH-1:0]   a_pipe [READ_LATENCY];
  logic [BRAM_DATA_WIDTH-1:0]   b_pipe [READ_LATENCY];
  logic [READ_LATENCY-1:0]      a_pv, b_pv;

  function automatic logic [BRAM_DATA_WIDTH-1:0] merge_bytes(
    input logic [BRAM_DATA_WIDTH-1:0] old_w,
    input logic [BRAM_DATA_WIDTH-1:0] new_w,
    input logic [NB-1:0]              ben_n
  );
    logic [BRAM_DATA_WIDTH-1:0] r;
    r = old_w;
    for (int unsigned i = 0; i < NB; i++) begin
      if (!ben_n[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) state_nxt = S_RUN;
      end
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_CLEAR;
    endcase
  end

  assign clr_busy = (state == S_CLEAR);

  // Accesses are only honoured in RUN and never on a reset edge.
  always_comb begin
    run       = (state == S_RUN) && !rst;
    clr_we    = (state == S_CLEAR) && !rst;
    a_we      = run && !a_chipselect_n && !a_write_n;
    a_re      = run && !a_chipselect_n && !a_read_n;
    b_re      = run && !b_chipselect_n && !b_read_n;
    a_old     = mem[a_addr];
    b_old     = mem[b_addr];
    a_new     = merge_bytes(a_old, a_data_in, a_byteen_n);
    a_rd_word = (WRITE_FIRST && a_we) ? a_new : a_old;
    b_rd_word = (WRITE_FIRST && a_we && (a_addr == b_addr)) ? a_new : b_old;
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt] <= INIT_VALUE;
    end else if (a_we) begin
      mem[a_addr] <= a_new;
    end
  end

  // Stage 0 captures at the accepting edge; the output register adds one more edge.
  always_ff @(posedge clk) begin
    if (a_re) a_pipe[0] <= a_rd_word;
    if (b_re) b_pipe[0] <= b_rd_word;
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      if (a_pv[i-1]) a_pipe[i] <= a_pipe[i-1];
      if (b_pv[i-1]) b_pipe[i] <= b_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_pv       <= '0;
      b_pv       <= '0;
      a_valid    <= 1'b0;
      b_valid    <= 1'b0;
      a_data_out <= '0;
      b_data_out <= '0;
    end else begin
      a_pv[0] <= a_re;
      b_pv[0] <= b_re;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        a_pv[i] <= a_pv[i-1];
        b_pv[i] <= b_pv[i-1];
      end
      a_valid <= a_pv[READ_LATENCY-1];
      b_valid <= b_pv[READ_LATENCY-1];
      if (a_pv[READ_LATENCY-1]) a_data_out <= a_pipe[READ_LATENCY-1];
      if (b_pv[READ_LATENCY-1]) b_data_out <= b_pipe[READ_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_bram_dp_clr.sv
// Testbench for bram_dp_clr: two instances (latency 1 / READ_FIRST, latency 2 / WRITE_FIRST)
// share the same stimulus and are checked every cycle against a queue-based reference model.
module tb_bram_dp_clr;

  localparam int          AW    = 4;
  localparam int          DW    = 16;
  localparam int          DEPTH = 16;
  localparam logic [15:0] INIT  = 16'hC3A5;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_cs_n, a_wr_n, a_rd_n, b_cs_n, b_rd_n;
  logic [1:0]        a_ben_n;
  logic [AW-1:0]     a_addr, b_addr;
  logic [DW-1:0]     a_din;
  logic [DW-1:0]     a_do [2];
  logic [DW-1:0]     b_do [2];
  logic              a_v [2];
  logic              b_v [2];
  logic              busy [2];

  always #5 clk = ~clk;

  bram_dp_clr #(
    .BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .READ_LATENCY(1),
    .WRITE_MODE("READ_FIRST"), .INIT_VALUE(INIT)
  ) u_rf1 (
    .clk(clk), .rst(rst),
    .a_chipselect_n(a_cs_n), .a_write_n(a_wr_n), .a_read_n(a_rd_n), .a_byteen_n(a_ben_n),
    .a_addr(a_addr), .a_data_in(a_din), .a_data_out(a_do[0]), .a_valid(a_v[0]),
    .b_chipselect_n(b_cs_n), .b_read_n(b_rd_n), .b_addr(b_addr),
    .b_data_out(b_do[0]), .b_valid(b_v[0]), .clr_busy(busy[0])
  );

  bram_dp_clr #(
    .BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .READ_LATENCY(2),
    .WRITE_MODE("WRITE_FIRST"), .INIT_VALUE(INIT)
  ) u_wf2 (
    .clk(clk), .rst(rst),
    .a_chipselect_n(a_cs_n), .a_write_n(a_wr_n), .a_read_n(a_rd_n), .a_byteen_n(a_ben_n),
    .a_addr(a_addr), .a_data_in(a_din), .a_data_out(a_do[1]), .a_valid(a_v[1]),
    .b_chipselect_n(b_cs_n), .b_read_n(b_rd_n), .b_addr(b_addr),
    .b_data_out(b_do[1]), .b_valid(b_v[1]), .clr_busy(busy[1])
  );

  typedef struct { int due; logic [15:0] d; } rd_t;

  // Reference model: memory as a plain array, pending reads as (due-cycle, word) queues.
  logic [15:0] mmem [DEPTH];
  int          busy_left;
  int          cyc;
  rd_t         qa0[$], qa1[$], qb0[$], qb1[$];
  logic [15:0] ea_d [2];
  logic [15:0] eb_d [2];
  logic        ea_v [2];
  logic        eb_v [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    logic        aw, ar, br;
    logic [15:0] old_a, mask, merged, word;
    rd_t         e;
    if (rst) begin
      busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mmem[i] = INIT;
      qa0.delete(); qa1.delete(); qb0.delete(); qb1.delete();
      for (int d = 0; d < 2; d++) begin
        ea_d[d] = '0; eb_d[d] = '0; ea_v[d] = 1'b0; eb_v[d] = 1'b0;
      end
      return;
    end
    for (int d = 0; d < 2; d++) begin
      ea_v[d] = 1'b0; eb_v[d] = 1'b0;
    end
    if (busy_left > 0) begin
      busy_left--;
    end else begin
      aw     = !a_cs_n && !a_wr_n;
      ar     = !a_cs_n && !a_rd_n;
      br     = !b_cs_n && !b_rd_n;
      old_a  = mmem[a_addr];
      mask   = {a_ben_n[1] ? 8'h00 : 8'hFF, a_ben_n[0] ? 8'h00 : 8'hFF};
      merged = (old_a & ~mask) | (a_din & mask);
      if (ar) begin
        e.due = cyc + 1; e.d = old_a;                      qa0.push_back(e);
        e.due = cyc + 2; e.d = aw ? merged : old_a;        qa1.push_back(e);
      end
      if (br) begin
        word  = mmem[b_addr];
        e.due = cyc + 1; e.d = word;                       qb0.push_back(e);
        e.due = cyc + 2; e.d = (aw && a_addr == b_addr) ? merged : word;
        qb1.push_back(e);
      end
      if (aw) mmem[a_addr] = merged;
    end
    if (qa0.size() > 0 && qa0[0].due == cyc) begin ea_v[0] = 1'b1; ea_d[0] = qa0.pop_front().d; end
    if (qa1.size() > 0 && qa1[0].due == cyc) begin ea_v[1] = 1'b1; ea_d[1] = qa1.pop_front().d; end
    if (qb0.size() > 0 && qb0[0].due == cyc) begin eb_v[0] = 1'b1; eb_d[0] = qb0.pop_front().d; end
    if (qb1.size() > 0 && qb1[0].due == cyc) begin eb_v[1] = 1'b1; eb_d[1] = qb1.pop_front().d; end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d clr_busy", d), 16'(busy[d]), 16'(busy_left > 0));
      chk($sformatf("dut%0d a_valid", d),  16'(a_v[d]),  16'(ea_v[d]));
      chk($sformatf("dut%0d b_valid", d),  16'(b_v[d]),  16'(eb_v[d]));
      chk($sformatf("dut%0d a_data", d),   a_do[d],      ea_d[d]);
      chk($sformatf("dut%0d b_data", d),   b_do[d],      eb_d[d]);
    end
  endtask

  task automatic drive(input logic acs, input logic aw, input logic ar, input logic [1:0] ben,
                       input logic [3:0] aa, input logic [15:0] ad,
                       input logic bcs, input logic br, input logic [3:0] ba);
    a_cs_n = !acs; a_wr_n = !aw; a_rd_n = !ar; a_ben_n = ben;
    a_addr = aa;   a_din  = ad;
    b_cs_n = !bcs; b_rd_n = !br; b_addr = ba;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 2'b11, 4'd0, 16'h0, 0, 0, 4'd0);
  endtask

  initial begin
    cyc = 0;
    busy_left = 0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;

    // Writes during CLEAR are ignored; restart the sequencer at cycle 5.
    for (int i = 0; i < 5; i++) drive(1, 1, 1, 2'b00, 4'd0, 16'h5555, 1, 1, 4'd0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) drive(1, 1, 1, 2'b00, 4'd0, 16'h5555, 1, 1, 4'(i));
    idle(2);

    for (int i = 0; i < 16; i++) drive(0, 0, 0, 2'b11, 4'd0, 16'h0, 1, 1, 4'(i));
    idle(3);

    // Write then read back, single and back-to-back.
    drive(1, 1, 0, 2'b00, 4'd3, 16'hBEEF, 0, 0, 4'd0);
    drive(0, 0, 0, 2'b11, 4'd0, 16'h0,    1, 1, 4'd3);
    idle(3);
    for (int i = 0; i < 4; i++) drive(1, 0, 1, 2'b11, 4'd3, 16'h0, 1, 1, 4'd3);
    idle(3);

    // Byte enables: only the low byte changes.
    drive(1, 1, 0, 2'b00, 4'd7, 16'h1234, 0, 0, 4'd0);
    drive(1, 1, 0, 2'b10, 4'd7, 16'hABCD, 0, 0, 4'd0);
    drive(1, 1, 0, 2'b11, 4'd7, 16'hFFFF, 0, 0, 4'd0);
    drive(1, 0, 1, 2'b11, 4'd7, 16'h0,    1, 1, 4'd7);
    idle(3);

    // Collisions between A write and A/B reads.
    drive(1, 1, 0, 2'b00, 4'd2, 16'h1111, 0, 0, 4'd0);
    drive(1, 1, 1, 2'b00, 4'd2, 16'h2222, 1, 1, 4'd2);
    drive(0, 0, 0, 2'b11, 4'd0, 16'h0,    1, 1, 4'd2);
    idle(2);
    drive(1, 1, 1, 2'b01, 4'd2, 16'h9988, 1, 1, 4'd2);
    drive(1, 1, 0, 2'b00, 4'd5, 16'h7777, 1, 1, 4'd2);
    idle(3);

    // Deselected strobes must be ignored; reset drops reads in flight.
    drive(0, 1, 1, 2'b00, 4'd2, 16'hDEAD, 0, 1, 4'd2);
    drive(1, 0, 1, 2'b11, 4'd2, 16'h0,    1, 1, 4'd5);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(17);
    drive(1, 0, 1, 2'b11, 4'd2, 16'h0,    1, 1, 4'd5);
    idle(3);

    // Randomised traffic with frequent address collisions and occasional reset.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] aa;
      rst = ($urandom_range(0, 149) == 0);
      aa  = 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), aa, 16'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) == 0) ? aa : 4'($urandom_range(0, 15)));
    end
    rst = 1'b0;
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
